// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional WAIT-state watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_BITS      = 8,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   input  logic [NUM_REQ*DATA_BITS-1:0] req_data_i,
   output logic [NUM_REQ-1:0]           req_ack_o,
   output logic [2:0]                   grant_id_o,
   output logic                         tx_send_o,
   output logic [DATA_BITS-1:0]         tx_data_o,
   input  logic                         tx_done_i,
   output logic                         busy_o,
   output logic                         tx_timeout_o
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

   state_t                 state_q;
   logic [2:0]             last_q;
   logic [2:0]             grant_q;
   logic [NUM_REQ-1:0]     ack_q;
   logic                   send_q;
   logic [DATA_BITS-1:0]   data_q;
   logic                   busy_q;

   logic                   found_d;
   logic [2:0]             sel_d;
   logic [NUM_REQ-1:0]     sel_oh_d;
   logic [DATA_BITS-1:0]   sel_data_d;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES - 1);
   logic [WDW-1:0] wd_q;
   logic           timeout_q;
   assign tx_timeout_o = timeout_q;
`else
   logic unused_cfg;
   assign unused_cfg   = ^TIMEOUT_CYCLES;
   assign tx_timeout_o = 1'b0;
`endif

   // First pending requester searching upward from last_grant+1, wrapping.
   always_comb begin
      int t;
      t          = 0;
      found_d    = 1'b0;
      sel_d      = '0;
      sel_oh_d   = '0;
      sel_data_d = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         t = int'(last_q) + k;
         if (t >= NUM_REQ) t = t - NUM_REQ;
         if (!found_d && req_valid_i[t]) begin
            found_d     = 1'b1;
            sel_d       = 3'(t);
            sel_oh_d[t] = 1'b1;
            sel_data_d  = req_data_i[t*DATA_BITS +: DATA_BITS];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         last_q    <= 3'(NUM_REQ - 1);
         grant_q   <= 3'(NUM_REQ - 1);
         ack_q     <= '0;
         send_q    <= 1'b0;
         data_q    <= '0;
         busy_q    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         wd_q      <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         ack_q  <= '0;
         send_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (found_d) begin
                  data_q  <= sel_data_d;
                  grant_q <= sel_d;
                  ack_q   <= sel_oh_d;
                  busy_q  <= 1'b1;
                  state_q <= S_SEND;
               end
            end
            S_SEND: begin
               send_q  <= 1'b1;
               state_q <= S_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
               wd_q    <= '0;
`endif
            end
            S_WAIT: begin
               // TX_DONE on the terminal-count cycle wins over the watchdog.
               if (tx_done_i) begin
                  last_q  <= grant_q;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
`ifdef UART_ARB_TIMEOUT_EN
               else if (wd_q == WD_MAX) begin
                  timeout_q <= 1'b1;
                  last_q    <= grant_q;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ack_o  = ack_q;
   assign grant_id_o = grant_q;
   assign tx_send_o  = send_q;
   assign tx_data_o  = data_q;
   assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner
// sequences and a randomized run against a queue-based round-robin model.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic        tx_done = 1'b0;
   logic [3:0]  req_ack;
   logic [2:0]  grant_id;
   logic        tx_send;
   logic [7:0]  tx_data;
   logic        busy;
   logic        tx_timeout;

   int errors = 0;
   int checks = 0;

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .TIMEOUT_CYCLES(16)) dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
      .req_ack_o(req_ack), .grant_id_o(grant_id), .tx_send_o(tx_send),
      .tx_data_o(tx_data), .tx_done_i(tx_done), .busy_o(busy),
      .tx_timeout_o(tx_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  exp_ack;
      logic [2:0]  exp_grant;
      logic [7:0]  exp_data;
   } vec_t;
   vec_t tbl[8];

   // reference model state: per-requester byte queues and last granted index
   logic [7:0] rq[4][16];
   int         rlen[4];
   int         m_last;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ack(output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (req_ack == 4'b0 && cnt < 50);
      if (req_ack == 4'b0) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: no REQ_ACK within 50 cycles");
      end
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_ack"}, 32'(req_ack), 32'h0);
      chk({name, "_send"}, 32'(tx_send), 32'h0);
      chk({name, "_data"}, 32'(tx_data), 32'h0);
      chk({name, "_grant"}, 32'(grant_id), 32'h3);
      chk({name, "_busy"}, 32'(busy), 32'h0);
      chk({name, "_tmo"}, 32'(tx_timeout), 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      tx_done = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic finish_txn();
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   function automatic int rr_pick(input int last);
      for (int k = 1; k <= 4; k++) begin
         if (rlen[(last + k) % 4] > 0) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_drive();
      for (int i = 0; i < 4; i++) begin
         req_valid[i]       = (rlen[i] > 0);
         req_data[i*8 +: 8] = (rlen[i] > 0) ? rq[i][0] : 8'h00;
      end
   endtask

   task automatic model_push(input int i);
      if (rlen[i] < 16) begin
         rq[i][rlen[i]] = 8'($urandom_range(0, 255));
         rlen[i]++;
      end
   endtask

   task automatic model_pop(input int i);
      for (int j = 0; j < 15; j++) rq[i][j] = rq[i][j+1];
      rlen[i]--;
   endtask

   initial begin
      int cnt;
      int pick;
      logic [7:0] exp_b;

      tbl[0] = '{4'b0001, 32'h000000A5, 4'b0001, 3'd0, 8'hA5};
      tbl[1] = '{4'b1111, 32'h43322110, 4'b0010, 3'd1, 8'h21};
      tbl[2] = '{4'b1010, 32'h43322110, 4'b1000, 3'd3, 8'h43};
      tbl[3] = '{4'b1010, 32'h43322110, 4'b0010, 3'd1, 8'h21};
      tbl[4] = '{4'b0001, 32'h43322110, 4'b0001, 3'd0, 8'h10};
      tbl[5] = '{4'b1001, 32'h43322110, 4'b1000, 3'd3, 8'h43};
      tbl[6] = '{4'b0110, 32'h43322110, 4'b0010, 3'd1, 8'h21};
      tbl[7] = '{4'b0100, 32'h43322110, 4'b0100, 3'd2, 8'h32};

      // reset state while reset is held
      tick();
      chk_reset_vals("reset");
      tick();
      rst = 1'b0;

      // table: each record is one full transaction starting in IDLE
      foreach (tbl[v]) begin
         req_valid = tbl[v].valid;
         req_data  = tbl[v].data;
         tick();
         chk($sformatf("t%0d_ack", v), 32'(req_ack), 32'(tbl[v].exp_ack));
         chk($sformatf("t%0d_grant", v), 32'(grant_id), 32'(tbl[v].exp_grant));
         chk($sformatf("t%0d_data", v), 32'(tx_data), 32'(tbl[v].exp_data));
         chk($sformatf("t%0d_busy", v), 32'(busy), 32'h1);
         chk($sformatf("t%0d_send0", v), 32'(tx_send), 32'h0);
         req_valid = '0;
         tick();
         chk($sformatf("t%0d_send", v), 32'(tx_send), 32'h1);
         chk($sformatf("t%0d_ack0", v), 32'(req_ack), 32'h0);
         tick();
         chk($sformatf("t%0d_sendoff", v), 32'(tx_send), 32'h0);
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         chk($sformatf("t%0d_idle", v), 32'(busy), 32'h0);
      end

      // all four held valid, TX_DONE 20 cycles after each TX_SEND
      do_reset();
      req_valid = 4'b1111;
      req_data  = 32'h43322110;
      for (int n = 0; n < 5; n++) begin
         wait_ack(cnt);
         chk($sformatf("rr%0d_grant", n), 32'(grant_id), 32'(n % 4));
         chk($sformatf("rr%0d_data", n), 32'(tx_data), 32'(8'h10 + 8'h11 * (n % 4)));
         tick();
         chk($sformatf("rr%0d_send", n), 32'(tx_send), 32'h1);
         repeat (19) tick();
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
      end
      req_valid = '0;

      // requests arriving during WAIT with last_grant=1
      do_reset();
      req_valid = 4'b0010;
      wait_ack(cnt);
      req_valid = '0;
      tick();
      for (int n = 0; n < 8; n++) begin
         req_valid = 4'($urandom);
         tick();
         chk("wait_noack", 32'(req_ack), 32'h0);
      end
      req_valid = 4'b1010;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      wait_ack(cnt);
      chk("pend_first", 32'(grant_id), 32'h3);
      finish_txn();
      wait_ack(cnt);
      chk("pend_second", 32'(grant_id), 32'h1);
      req_valid = '0;
      finish_txn();

      // spurious TX_DONE in IDLE and SEND, then exact back-to-back gap
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("spur_idle_busy", 32'(busy), 32'h0);
      chk("spur_idle_ack", 32'(req_ack), 32'h0);
      req_valid = 4'b0001;
      tick();
      chk("spur_ack", 32'(req_ack), 32'h1);
      req_valid = '0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("spur_send", 32'(tx_send), 32'h1);
      repeat (3) begin
         tick();
         chk("spur_still_busy", 32'(busy), 32'h1);
      end
      req_valid = 4'b0100;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("done_busy", 32'(busy), 32'h0);
      wait_ack(cnt);
      chk("gap_ack_cycles", 32'(cnt), 32'h1);
      chk("gap_grant", 32'(grant_id), 32'h2);
      req_valid = '0;
      tick();
      chk("gap_send", 32'(tx_send), 32'h1);

      // asynchronous reset during WAIT
      tick();
      #2 rst = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      @(posedge clk);
      #1 rst = 1'b0;
      req_valid = 4'b1111;
      wait_ack(cnt);
      chk("post_rst_grant", 32'(grant_id), 32'h0);
      req_valid = '0;
      finish_txn();

`ifdef UART_ARB_TIMEOUT_EN
      // watchdog abort, then TX_DONE on the terminal-count cycle
      req_valid = 4'b0001;
      wait_ack(cnt);
      req_valid = 4'b0100;
      tick();
      cnt = 0;
      for (int j = 1; j <= 40; j++) begin
         tick();
         if (tx_timeout) begin
            cnt = j;
            break;
         end
      end
      chk("tmo_cycles", 32'(cnt), 32'd16);
      chk("tmo_busy", 32'(busy), 32'h0);
      wait_ack(cnt);
      chk("tmo_next_grant", 32'(grant_id), 32'h2);
      chk("tmo_next_cnt", 32'(cnt), 32'h1);
      req_valid = '0;
      tick();
      for (int j = 1; j <= 15; j++) begin
         tick();
         chk("tmo_quiet", 32'(tx_timeout), 32'h0);
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("tmo_done_wins", 32'(tx_timeout), 32'h0);
      chk("tmo_done_idle", 32'(busy), 32'h0);
      tick();
      chk("tmo_done_after", 32'(tx_timeout), 32'h0);
`endif

      // randomized traffic against the queue model
      do_reset();
      m_last = 3;
      for (int i = 0; i < 4; i++) rlen[i] = 0;
      for (int n = 0; n < 200; n++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) model_push(i);
         if (rr_pick(m_last) < 0) model_push(int'($urandom_range(0, 3)));
         model_drive();
         pick  = rr_pick(m_last);
         exp_b = rq[pick][0];
         wait_ack(cnt);
         chk("rnd_ack", 32'(req_ack), 32'(4'b1 << pick));
         chk("rnd_grant", 32'(grant_id), 32'(pick));
         chk("rnd_data", 32'(tx_data), 32'(exp_b));
         model_pop(pick);
         model_drive();
         tick();
         chk("rnd_send", 32'(tx_send), 32'h1);
         repeat ($urandom_range(1, 6)) begin
            if ($urandom_range(0, 2) == 0) model_push(int'($urandom_range(0, 3)));
            model_drive();
            tick();
            chk("rnd_wait_ack", 32'(req_ack), 32'h0);
            chk("rnd_wait_data", 32'(tx_data), 32'(exp_b));
         end
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         chk("rnd_idle", 32'(busy), 32'h0);
         m_last = pick;
      end
      req_valid = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
